// File: rtl/vx_tensor_dpu_arbiter.sv
// Round-robin arbiter sharing one tensor DPU between NUM_REQS issue requesters.
// Multi-beat HMMA sequences are granted atomically; an in-order tag queue steers results back.
module vx_tensor_dpu_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int REQ_DATAW = 1056,
  parameter int RSP_DATAW = 517,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS-1:0]           req_last,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          dpu_valid_in,
  input  logic                          dpu_ready_in,
  output logic [REQ_DATAW-1:0]          dpu_data_in,
  input  logic                          dpu_valid_out,
  output logic                          dpu_ready_out,
  input  logic [RSP_DATAW-1:0]          dpu_data_out,
  output logic [NUM_REQS-1:0]           rsp_valid,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic [RSP_DATAW-1:0]          rsp_data,
  output logic                          busy
);

  localparam int LW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = TW + 1;
  localparam logic [LW:0] NR = (LW+1)'(NUM_REQS);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [LW-1:0]   r_owner;
  logic [LW-1:0]   w_owner_next;
  logic [LW-1:0]   r_rr_ptr;
  logic [LW-1:0]   w_rr_ptr_next;

  logic [LW-1:0]   r_tag_mem [TAG_DEPTH];
  logic [TW-1:0]   r_wr_ptr;
  logic [TW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [REQ_DATAW-1:0] w_req_data [NUM_REQS];
  logic [LW-1:0]   w_scan_sel;
  logic [LW-1:0]   w_sel;
  logic [LW-1:0]   w_head;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic            w_fire;
  logic            w_pop;
  logic            w_sel_last;

  function automatic logic [LW-1:0] f_wrap(input logic [LW-1:0] base, input logic [LW:0] ofs);
    logic [LW:0] s;
    s = {1'b0, base} + ofs;
    if (s >= NR) s = s - NR;
    return s[LW-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
      assign w_req_data[gi] = req_data[gi*REQ_DATAW +: REQ_DATAW];
    end
  endgenerate

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    w_scan_sel = r_rr_ptr;
    for (int k = NUM_REQS-1; k >= 0; k--) begin
      if (req_valid[f_wrap(r_rr_ptr, (LW+1)'(k))]) w_scan_sel = f_wrap(r_rr_ptr, (LW+1)'(k));
    end
  end

  assign w_sel       = (r_state == S_LOCKED) ? r_owner : w_scan_sel;
  assign w_sel_last  = req_last[w_sel];
  assign w_tag_full  = (r_count == CW'(TAG_DEPTH));
  assign w_tag_empty = (r_count == '0);
  assign w_head      = r_tag_mem[r_rd_ptr];

  assign dpu_valid_in  = reset && req_valid[w_sel] && !w_tag_full;
  assign dpu_data_in   = w_req_data[w_sel];
  assign w_fire        = dpu_valid_in && dpu_ready_in;
  assign dpu_ready_out = reset && !w_tag_empty && rsp_ready[w_head];
  assign w_pop         = dpu_valid_out && dpu_ready_out;
  assign rsp_data      = dpu_data_out;
  assign busy          = reset && ((r_state == S_LOCKED) || !w_tag_empty);

  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_ports
      assign req_ready[gi] = reset && (w_sel == LW'(gi)) && dpu_ready_in && !w_tag_full;
      assign rsp_valid[gi] = reset && dpu_valid_out && !w_tag_empty && (w_head == LW'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    if (w_fire) begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_last) begin
            w_rr_ptr_next = f_wrap(w_sel, (LW+1)'(1));
          end else begin
            w_state_next = S_LOCKED;
            w_owner_next = w_sel;
          end
        end
        S_LOCKED: begin
          if (w_sel_last) begin
            w_state_next  = S_IDLE;
            w_rr_ptr_next = f_wrap(r_owner, (LW+1)'(1));
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
      if (w_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_fire) r_tag_mem[r_wr_ptr] <= w_sel;
  end

  a_rsp_has_tag: assert property (@(posedge clk) disable iff (!reset) dpu_valid_out |-> !w_tag_empty);

endmodule

// File: tb/tb_vx_tensor_dpu_arbiter.sv
// Randomized and directed bench for vx_tensor_dpu_arbiter, checked against a queue-based model.
module tb_vx_tensor_dpu_arbiter;
  localparam int NR  = 4;
  localparam int RQW = 1056;
  localparam int RSW = 517;
  localparam int TD  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR-1:0]     req_valid, req_last, req_ready, rsp_valid, rsp_ready;
  logic [NR*RQW-1:0] req_data;
  logic              dpu_valid_in, dpu_ready_in, dpu_valid_out, dpu_ready_out, busy;
  logic [RQW-1:0]    dpu_data_in;
  logic [RSW-1:0]    dpu_data_out, rsp_data;

  vx_tensor_dpu_arbiter #(.NUM_REQS(NR), .REQ_DATAW(RQW), .RSP_DATAW(RSW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .dpu_valid_in(dpu_valid_in), .dpu_ready_in(dpu_ready_in), .dpu_data_in(dpu_data_in),
    .dpu_valid_out(dpu_valid_out), .dpu_ready_out(dpu_ready_out), .dpu_data_out(dpu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: issued-tag FIFO, lock owner (or none), next round-robin start.
  int          m_q[$];
  bit          m_locked;
  int          m_owner;
  int          m_rr;
  int          rem[NR];
  logic [RQW-1:0] pay[NR];

  task automatic check(input string tag, input logic [RQW-1:0] got, input logic [RQW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RQW-1:0] rnd_req();
    logic [RQW-1:0] v;
    for (int w = 0; w < RQW/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [RSW-1:0] rnd_rsp();
    logic [543:0] v;
    for (int w = 0; w < 17; w++) v[w*32 +: 32] = $urandom();
    return v[RSW-1:0];
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
  endtask

  task automatic new_payloads();
    for (int i = 0; i < NR; i++) begin
      pay[i] = rnd_req();
      req_data[i*RQW +: RQW] = pay[i];
    end
    dpu_data_out = rnd_rsp();
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances the model at the rising edge.
  task automatic step();
    int sel, head;
    bit sel_def, full, empty, exp_vin, exp_dro, fire, pop;
    logic [NR-1:0] exp_rdy, exp_rv;
    #1;
    if (!reset) begin
      check("rst_req_ready", RQW'(req_ready), '0);
      check("rst_dpu_valid_in", RQW'(dpu_valid_in), '0);
      check("rst_dpu_ready_out", RQW'(dpu_ready_out), '0);
      check("rst_rsp_valid", RQW'(rsp_valid), '0);
      check("rst_busy", RQW'(busy), '0);
      @(posedge clk);
      m_reset();
      return;
    end
    full  = (m_q.size() >= TD);
    empty = (m_q.size() == 0);
    sel_def = 1'b0;
    sel = 0;
    if (m_locked) begin
      sel = m_owner;
      sel_def = 1'b1;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (!sel_def && req_valid[(m_rr + k) % NR]) begin
          sel = (m_rr + k) % NR;
          sel_def = 1'b1;
        end
      end
    end
    exp_vin = sel_def && req_valid[sel] && !full;
    exp_rdy = (sel_def && dpu_ready_in && !full) ? NR'(1 << sel) : '0;
    head    = empty ? 0 : m_q[0];
    exp_rv  = (dpu_valid_out && !empty) ? NR'(1 << head) : '0;
    exp_dro = !empty && rsp_ready[head];

    check("dpu_valid_in", RQW'(dpu_valid_in), RQW'(exp_vin));
    if (sel_def) check("req_ready", RQW'(req_ready), RQW'(exp_rdy));
    else         check("req_ready_noaccept", RQW'(req_ready & req_valid), '0);
    if (exp_vin) check("dpu_data_in", dpu_data_in, pay[sel]);
    check("rsp_valid", RQW'(rsp_valid), RQW'(exp_rv));
    check("dpu_ready_out", RQW'(dpu_ready_out), RQW'(exp_dro));
    if (exp_rv != '0) check("rsp_data", RQW'(rsp_data), RQW'(dpu_data_out));
    check("busy", RQW'(busy), RQW'(m_locked || !empty));

    fire = exp_vin && dpu_ready_in;
    pop  = dpu_valid_out && exp_dro;
    @(posedge clk);
    if (pop) begin
      $display("result req=%0d qlen=%0d", m_q[0], m_q.size() - 1);
      void'(m_q.pop_front());
    end
    if (fire) begin
      m_q.push_back(sel);
      $display("issue  req=%0d last=%0d qlen=%0d", sel, req_last[sel], m_q.size());
      if (req_last[sel]) begin
        m_locked = 1'b0;
        m_rr = (sel + 1) % NR;
      end else begin
        m_locked = 1'b1;
        m_owner = sel;
      end
      rem[sel]--;
      if (rem[sel] <= 0) rem[sel] = $urandom_range(1, 4);
    end
  endtask

  task automatic cyc(input logic rst, input logic [NR-1:0] v, input logic [NR-1:0] l,
                     input logic dri, input logic dvo, input logic [NR-1:0] rr);
    @(negedge clk);
    reset = rst; req_valid = v; req_last = l; dpu_ready_in = dri;
    dpu_valid_out = dvo && (m_q.size() > 0); rsp_ready = rr;
    new_payloads();
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && m_q.size() > 0; n++) cyc(1'b1, '0, '0, 1'b1, 1'b1, '1);
  endtask

  task automatic rnd_cycle(input int pv, input int pdv);
    logic [NR-1:0] v, l, rr;
    for (int i = 0; i < NR; i++) begin
      v[i]  = ($urandom_range(99) < pv);
      l[i]  = (rem[i] == 1);
      rr[i] = ($urandom_range(99) < 70);
    end
    cyc(($urandom_range(199) != 0), v, l, ($urandom_range(99) < 80), ($urandom_range(99) < pdv), rr);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rem[i] = 1;
    m_reset();
    reset = 1'b0; req_valid = '0; req_last = '0; dpu_ready_in = 1'b0;
    dpu_valid_out = 1'b0; rsp_ready = '0; new_payloads();

    // Reset with every input active: outputs must stay low.
    for (int n = 0; n < 3; n++) cyc(1'b0, '1, '1, 1'b1, 1'b1, '1);

    // Single requester, three-beat sequence, then its three results.
    cyc(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, '1);  // rr_ptr=3 -> requester 3 first
    drain();

    // Contention with one-beat sequences from rr_ptr=0.
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 5; n++) cyc(1'b1, '1, '1, 1'b1, 1'b1, '1);
    drain();

    // Lock hold through an owner bubble.
    cyc(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b1011, 4'b1011, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b0, '1);
    drain();

    // Fill the tag queue, then pop while a request waits.
    for (int n = 0; n < TD + 1; n++) cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, '1);
    cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, '1);
    cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, '1);
    drain();

    // Response backpressure on head tag 2.
    cyc(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, '1);
    cyc(1'b1, '0, '0, 1'b1, 1'b1, 4'b1011);
    cyc(1'b1, '0, '0, 1'b1, 1'b1, 4'b1011);
    cyc(1'b1, '0, '0, 1'b1, 1'b1, 4'b0100);
    drain();

    // Reset while locked with five tags queued, then requester 0 wins.
    for (int n = 0; n < 5; n++) cyc(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, '1);
    cyc(1'b0, '1, '0, 1'b1, 1'b0, '1);
    cyc(1'b1, '1, '1, 1'b1, 1'b0, '1);
    drain();

    // Randomized traffic, alternating result-rate regimes to reach full and empty.
    for (int ph = 0; ph < 6; ph++) begin
      int pdv;
      pdv = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 60 : 95);
      for (int n = 0; n < 250; n++) rnd_cycle(60, pdv);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_tensor_dpu_arbiter.md
# vx_tensor_dpu_arbiter

Round-robin arbiter sharing one tensor dot-product unit (DPU) between `NUM_REQS` issue requesters (e.g. per-sub-core HMMA issue slots). It grants whole multi-beat HMMA sequences atomically so beats from different requesters never interleave at the DPU input. It records the requester index of every issued beat in an in-order tag queue and steers each DPU result back to the requester that issued it. It sits between the tensor issue logic and the DPU's valid/ready ports.

## Interface
- `NUM_REQS`, 4: number of requesters (≥2).
- `REQ_DATAW`, 1056: per-beat operand payload width (A/B/C tiles plus warp id).
- `RSP_DATAW`, 517: DPU result width (D tile plus warp id).
- `TAG_DEPTH`, 16: tag queue depth, power of 2, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low: 0 = reset.
- `req_valid`  in  NUM_REQS  per-requester beat valid.
- `req_last`  in  NUM_REQS  beat is the last of its HMMA sequence.
- `req_data`  in  NUM_REQS×REQ_DATAW  per-requester payload.
- `req_ready`  out  NUM_REQS  beat accepted (one-hot or zero).
- `dpu_valid_in`  out  1  beat to DPU.
- `dpu_ready_in`  in  1  DPU accepts beat.
- `dpu_data_in`  out  REQ_DATAW  granted payload.
- `dpu_valid_out`  in  1  DPU result valid.
- `dpu_ready_out`  out  1  result consumed.
- `dpu_data_out`  in  RSP_DATAW  DPU result.
- `rsp_valid`  out  NUM_REQS  result valid, one-hot at the tag-queue head index.
- `rsp_ready`  in  NUM_REQS  per-requester result accept.
- `rsp_data`  out  RSP_DATAW  shared result bus, equal to `dpu_data_out`.
- `busy`  out  1  state LOCKED or tag queue non-empty.

## Operation
- State: IDLE or LOCKED(owner). Registers: `state`, `owner` and `rr_ptr` (each log2(NUM_REQS) bits), tag queue (TAG_DEPTH × log2(NUM_REQS)) with occupancy count.
- Selection `sel`:
  - IDLE: the first i with `req_valid[i]`, scanning from `rr_ptr` upward with wrap.
  - LOCKED: `sel = owner`, regardless of the other requesters' valids.
- `dpu_valid_in = req_valid[sel] && !tag_full`. `dpu_data_in = req_data[sel]`.
- `req_ready[i] = (i==sel) && dpu_ready_in && !tag_full`.
- Issue fire = `dpu_valid_in && dpu_ready_in`.
- On fire, push `sel` into the tag queue.
- Transitions on fire:
  - IDLE with `last=0` → LOCKED, `owner=sel`.
  - IDLE with `last=1` → stay IDLE, `rr_ptr = (sel+1) mod NUM_REQS`.
  - LOCKED with `last=1` → IDLE, `rr_ptr = (owner+1) mod NUM_REQS`.
  - LOCKED with `last=0` → stay LOCKED.
- LOCKED while the owner has `req_valid=0`: issue a bubble. The lock is held and no other requester is granted.
- Response path, with `head` = tag-queue head:
  - `rsp_valid[i] = dpu_valid_out && !tag_empty && i==head`.
  - `dpu_ready_out = !tag_empty && rsp_ready[head]`.
  - Pop the tag queue on `dpu_valid_out && dpu_ready_out`.
- Full/empty:
  - Issue is blocked when the tag queue is full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged, and the pointers wrap mod TAG_DEPTH.
- `dpu_valid_out` with an empty tag queue is a protocol error:
  - Runtime assert fires.
  - `dpu_ready_out = 0` and all `rsp_valid = 0`.
- Reset (`reset=0`), including mid-sequence or with results in flight:
  - Next edge: state IDLE, `owner=0`, `rr_ptr=0`, tag queue empty.
  - All outputs are 0 while `reset=0`: `req_ready`, `dpu_valid_in`, `dpu_ready_out`, `rsp_valid`, `busy`.

## Timing
- Request → DPU: 0 cycles, combinational pass-through. Arbitration state updates at the edge after fire.
- DPU result → requester: 0 cycles, combinational.
- `req_ready[i]` may depend on `req_valid` (through `sel`). Requesters must not make `req_valid` depend on `req_ready`.
- Throughput: 1 beat/cycle sustained when the DPU and the tag queue permit.
- Fairness: after a sequence ends, the finishing requester has lowest priority in the next arbitration.
- In-order: rsp order equals issue order, since the DPU is in-order.

## Test plan
- Single requester: req 2 issues 3 beats with `last` on beat 3 → granted back-to-back; tags 2,2,2 pushed; `rr_ptr=3` after beat 3; 3 responses on `rsp_valid=4'b0100`.
- Contention: all 4 requesters valid with 1-beat sequences, `rr_ptr=0` → grant order 0,1,2,3,0; each `req_ready` is one-hot.
- Lock hold: req 1 sends beat (`last=0`), then drops valid 2 cycles while req 0 and req 3 are valid → `dpu_valid_in=0` both cycles; req 1 is granted on return; req 3 is granted first after req 1's `last`.
- Full queue: `dpu_valid_out` held 0 and 16 beats issued → `dpu_valid_in=0` on the 17th; then a pop in the same cycle as a valid request → still blocked that cycle, issue resumes the next cycle.
- Response backpressure: head tag=2 with `rsp_ready[2]=0` → `dpu_ready_out=0`, no pop; `rsp_ready[2]=1` → pop and head advances.
- Reset mid-operation: assert `reset=0` while LOCKED with 5 tags queued → next cycle state IDLE, `busy=0`, all outputs 0. After release, requester 0 wins first.
